// File: rtl/temp_spi_sampler.sv
// temp_spi_sampler
//   SPI mode-0 acquisition front end for a 16-bit digital temperature sensor.
//   Reads one frame per trigger, extracts the 13-bit two's-complement reading
//   from frame[15:3] (0.0625 C/LSB), and tracks min, max and a hysteresis alarm.
//
// Ports
//   ACLK, ARESETN        clock, synchronous active-low reset
//   enable               periodic sampling enable (every SAMPLE_PERIOD cycles)
//   start                one-cycle software trigger
//   thr_high, thr_low    signed alarm set / clear thresholds
//   spi_miso             sensor data in
//   spi_sclk, spi_cs_n   SPI clock (idles low), chip select (active low)
//   temp_data            last reading, sign-extended; temp_valid pulses on update
//   temp_min, temp_max   signed extremes since reset
//   alarm                over-temperature flag with hysteresis
//   busy                 frame in progress
//   sample_cnt           completed frames, wraps
module temp_spi_sampler #(
    parameter int CLK_DIV       = 50,
    parameter int SAMPLE_PERIOD = 100000
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        enable,
    input  logic        start,
    input  logic [15:0] thr_high,
    input  logic [15:0] thr_low,
    input  logic        spi_miso,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic [15:0] temp_data,
    output logic        temp_valid,
    output logic [15:0] temp_min,
    output logic [15:0] temp_max,
    output logic        alarm,
    output logic        busy,
    output logic [31:0] sample_cnt
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);

    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, UPDATE} state_t;

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [3:0]         bit_cnt;
    logic [15:0]        shreg;
    logic [PER_W-1:0]   per_cnt;
    logic               per_trig;
    logic               trig;
    logic               div_done;
    logic signed [15:0] new_temp;

    assign per_trig = enable && (per_cnt == PER_LAST);
    assign trig     = start || per_trig;
    assign div_done = (div_cnt == DIV_LAST);
    // Sensor puts the reading in the top 13 bits; low 3 bits are flags/unused.
    assign new_temp = {{3{shreg[15]}}, shreg[15:3]};

    // Free-running period counter; it keeps counting during a frame, so a
    // period trigger that lands while busy is simply lost.
    always_ff @(posedge ACLK) begin
        if (!ARESETN || !enable || per_trig)
            per_cnt <= '0;
        else
            per_cnt <= per_cnt + 1'b1;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            spi_sclk   <= 1'b0;
            spi_cs_n   <= 1'b1;
            temp_data  <= '0;
            temp_valid <= 1'b0;
            temp_min   <= 16'h7FFF;
            temp_max   <= 16'h8000;
            alarm      <= 1'b0;
            busy       <= 1'b0;
            sample_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig) begin
                        state    <= CS_SETUP;
                        spi_cs_n <= 1'b0;
                        busy     <= 1'b1;
                        div_cnt  <= '0;
                    end
                end
                CS_SETUP: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        if (!spi_sclk) begin
                            // Sample on the same edge that raises SCLK; the
                            // sensor has held the bit for the whole low phase.
                            spi_sclk <= 1'b1;
                            shreg    <= {shreg[14:0], spi_miso};
                        end else begin
                            spi_sclk <= 1'b0;
                            if (bit_cnt == 4'd15)
                                state <= CS_HOLD;
                            else
                                bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                CS_HOLD: begin
                    if (div_done) begin
                        div_cnt    <= '0;
                        state      <= UPDATE;
                        spi_cs_n   <= 1'b1;
                        busy       <= 1'b0;
                        temp_valid <= 1'b1;
                        temp_data  <= new_temp;
                        sample_cnt <= sample_cnt + 1'b1;
                        if (new_temp < $signed(temp_min))
                            temp_min <= new_temp;
                        if (new_temp > $signed(temp_max))
                            temp_max <= new_temp;
                        // Set is tested first so it wins when thr_low > thr_high.
                        if (new_temp > $signed(thr_high))
                            alarm <= 1'b1;
                        else if (new_temp < $signed(thr_low))
                            alarm <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                UPDATE: begin
                    temp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_spi_sampler.sv
// Bench for temp_spi_sampler: directed frames from a mode-0 sensor model,
// expectations queued at stimulus time and checked by a monitor on temp_valid,
// plus an SPI framing monitor.
module tb_temp_spi_sampler;

    localparam int CD = 4;
    localparam int SP = 2000;
    localparam int LAT = 34 * CD + 1;

    logic        ACLK = 1'b0;
    logic        ARESETN, enable, start, spi_miso;
    logic [15:0] thr_high, thr_low;
    logic        spi_sclk, spi_cs_n, temp_valid, alarm, busy;
    logic [15:0] temp_data, temp_min, temp_max;
    logic [31:0] sample_cnt;

    temp_spi_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .start(start),
        .thr_high(thr_high), .thr_low(thr_low), .spi_miso(spi_miso),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .temp_data(temp_data),
        .temp_valid(temp_valid), .temp_min(temp_min), .temp_max(temp_max),
        .alarm(alarm), .busy(busy), .sample_cnt(sample_cnt)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [15:0] data, mn, mx;
        logic        al;
        logic [31:0] cnt;
        int          ref_cyc;
    } exp_t;
    exp_t sb[$];

    // Sensor model: first bit on CS fall, next bit after each SCLK fall.
    logic [15:0] sensor_frame = 16'h0;
    int          sidx = 0;
    logic        s_prev_sclk = 1'b0;
    initial begin
        spi_miso = 1'b0;
        forever begin
            @(negedge ACLK);
            if (spi_cs_n !== 1'b0) sidx = 0;
            else if (s_prev_sclk && !spi_sclk) sidx++;
            spi_miso = (sidx < 16) ? sensor_frame[15 - sidx] : 1'b0;
            s_prev_sclk = spi_sclk;
        end
    end

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge ACLK);
            if (ARESETN && temp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("temp_data", {16'h0, temp_data}, {16'h0, e.data});
                    chk("temp_min", {16'h0, temp_min}, {16'h0, e.mn});
                    chk("temp_max", {16'h0, temp_max}, {16'h0, e.mx});
                    chk("alarm", {31'h0, alarm}, {31'h0, e.al});
                    chk("sample_cnt", sample_cnt, e.cnt);
                    chk("latency", cyc - e.ref_cyc, LAT);
                    chk("busy_at_valid", {31'h0, busy}, 32'd0);
                end
            end
        end
    end

    // SPI framing monitor: phase lengths, edge count, CS setup/hold, idle SCLK.
    logic pc = 1'b1, ps = 1'b0, in_frame = 1'b0, aborted = 1'b0, bad = 1'b0, idle_bad = 1'b0;
    int   run = 0, edges = 0;
    initial begin
        forever begin
            @(negedge ACLK);
            if (!ARESETN && in_frame) aborted = 1'b1;
            if (spi_cs_n === 1'b1 && spi_sclk === 1'b1) idle_bad = 1'b1;
            if (spi_cs_n === 1'b0 && pc) begin
                in_frame = 1'b1; aborted = 1'b0; bad = 1'b0; edges = 0; run = 1;
                if (spi_sclk !== 1'b0) bad = 1'b1;
            end else if (spi_cs_n === 1'b0) begin
                if (spi_sclk !== ps) begin
                    if (spi_sclk) begin
                        edges++;
                        if (run != ((edges == 1) ? 2 * CD : CD)) bad = 1'b1;
                    end else if (run != CD) bad = 1'b1;
                    run = 1;
                end else run++;
            end else if (!pc && in_frame) begin
                if (!aborted) begin
                    if (run != CD || ps) bad = 1'b1;
                    chk("sclk_edges", edges, 16);
                    chk("sclk_timing", {31'h0, bad}, 32'd0);
                end
                in_frame = 1'b0; aborted = 1'b0;
            end
            pc = (spi_cs_n === 1'b0) ? 1'b0 : 1'b1;
            ps = (spi_sclk === 1'b1);
        end
    end

    task automatic wait_drain(input int max);
        int n = 0;
        while (sb.size() != 0 && n < max) begin
            @(negedge ACLK); n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge ACLK);
    endtask

    task automatic run_frame(input logic [15:0] frame, input logic [15:0] d,
                             input logic [15:0] mn, input logic [15:0] mx,
                             input logic al, input logic [31:0] cnt);
        exp_t e;
        sensor_frame = frame;
        @(negedge ACLK);
        start = 1'b1;
        e = '{data: d, mn: mn, mx: mx, al: al, cnt: cnt, ref_cyc: cyc};
        sb.push_back(e);
        @(negedge ACLK);
        start = 1'b0;
        wait_drain(LAT + 50);
    endtask

    initial begin
        int   n, ed, base;
        logic pl;
        exp_t e;
        ARESETN = 1'b0; enable = 1'b0; start = 1'b0;
        thr_high = 16'h0320; thr_low = 16'h02D0;
        repeat (3) @(negedge ACLK);
        chk("rst_cs_n", {31'h0, spi_cs_n}, 32'd1);
        chk("rst_sclk", {31'h0, spi_sclk}, 32'd0);
        chk("rst_min", {16'h0, temp_min}, 32'h7FFF);
        chk("rst_max", {16'h0, temp_max}, 32'h8000);
        chk("rst_cnt_busy_valid", {sample_cnt[29:0], busy, temp_valid}, 32'd0);
        ARESETN = 1'b1;

        run_frame(16'h0C80, 16'h0190, 16'h0190, 16'h0190, 1'b0, 32'd1);  // +25.0 C
        run_frame(16'hF380, 16'hFE70, 16'hFE70, 16'h0190, 1'b0, 32'd2);  // -25.0 C
        run_frame(16'h1980, 16'h0330, 16'hFE70, 16'h0330, 1'b1, 32'd3);  // above high: set
        run_frame(16'h1700, 16'h02E0, 16'hFE70, 16'h0330, 1'b1, 32'd4);  // in band: hold
        run_frame(16'h1600, 16'h02C0, 16'hFE70, 16'h0330, 1'b0, 32'd5);  // below low: clear

        // Reset during bit 7 of a frame.
        sensor_frame = 16'h1980;
        @(negedge ACLK); start = 1'b1;
        @(negedge ACLK); start = 1'b0;
        n = 0; ed = 0; pl = 1'b0;
        while (ed < 7 && n < 1000) begin
            @(negedge ACLK);
            if (spi_sclk && !pl) ed++;
            pl = spi_sclk; n++;
        end
        chk("reach_bit7", ed, 7);
        repeat (CD + 1) @(negedge ACLK);
        chk("mid_frame_busy", {31'h0, busy}, 32'd1);
        ARESETN = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        chk("midrst_cs_n", {31'h0, spi_cs_n}, 32'd1);
        chk("midrst_sclk", {31'h0, spi_sclk}, 32'd0);
        chk("midrst_min", {16'h0, temp_min}, 32'h7FFF);
        chk("midrst_max", {16'h0, temp_max}, 32'h8000);
        chk("midrst_cnt", sample_cnt, 32'd0);
        chk("midrst_busy", {31'h0, busy}, 32'd0);
        chk("midrst_data", {16'h0, temp_data}, 32'd0);
        run_frame(16'h0C80, 16'h0190, 16'h0190, 16'h0190, 1'b0, 32'd1);

        // thr_low > thr_high: set wins; then reading equal to both thresholds holds.
        thr_high = 16'h0100; thr_low = 16'h0200;
        run_frame(16'h0C00, 16'h0180, 16'h0180, 16'h0190, 1'b1, 32'd2);
        thr_high = 16'h0180; thr_low = 16'h0180;
        run_frame(16'h0C00, 16'h0180, 16'h0180, 16'h0190, 1'b1, 32'd3);
        thr_high = 16'h0320; thr_low = 16'h02D0;

        // Periodic sampling; start pulses while busy must be dropped.
        sensor_frame = 16'h0C80;
        @(negedge ACLK);
        enable = 1'b1;
        base = cyc;
        for (int k = 0; k < 3; k++) begin
            e = '{data: 16'h0190, mn: 16'h0180, mx: 16'h0190, al: 1'b0,
                  cnt: 32'(4 + k), ref_cyc: base + SP - 1 + k * SP};
            sb.push_back(e);
        end
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (busy !== 1'b1 && n < 3000) begin @(negedge ACLK); n++; end
            chk("periodic_busy_seen", {31'h0, busy}, 32'd1);
            repeat (10) @(negedge ACLK);
            start = 1'b1;
            @(negedge ACLK);
            start = 1'b0;
            n = 0;
            while (busy !== 1'b0 && n < 3000) begin @(negedge ACLK); n++; end
        end
        wait_drain(SP + 200);
        enable = 1'b0;
        repeat (SP + 500) @(negedge ACLK);
        chk("final_cnt", sample_cnt, 32'd6);
        chk("sclk_idle_low", {31'h0, idle_bad}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/temp_spi_sampler.md
Name: temp_spi_sampler

Overview:
Acquisition front end for the temperature IP. Runs an SPI mode-0 read of a 16-bit digital temperature sensor frame and extracts the 13-bit two's-complement reading (0.0625 °C/LSB). Tracks min, max and a hysteresis alarm. Its outputs feed the AXI4-Lite register bank of my_ip_temperatura directly downstream, which exposes them to software.

Parameters:
CLK_DIV, 50, SCLK half-period in ACLK cycles (>=2)
SAMPLE_PERIOD, 100000, ACLK cycles between automatic samples when enabled (>=34*CLK_DIV+2)

Ports:
ACLK  in  1  system clock
ARESETN  in  1  synchronous active-low reset
enable  in  1  periodic sampling enable
start  in  1  one-cycle software trigger (from register bank)
thr_high  in  16  signed alarm set threshold
thr_low  in  16  signed alarm clear threshold
spi_miso  in  1  sensor data out
spi_sclk  out  1  SPI clock, idles low
spi_cs_n  out  1  sensor chip select, active low
temp_data  out  16  last reading, sign-extended
temp_valid  out  1  one-cycle pulse when temp_data updates
temp_min  out  16  signed minimum since reset
temp_max  out  16  signed maximum since reset
alarm  out  1  over-temperature flag with hysteresis
busy  out  1  frame in progress
sample_cnt  out  32  completed frames, wraps at 2^32

Behaviour:
- One clock: ACLK. Reset: ARESETN, synchronous, active-low. All state updates on the rising edge of ACLK.
- Reset values:
  - spi_sclk=0, spi_cs_n=1, temp_data=0, temp_valid=0.
  - temp_min=16'h7FFF, temp_max=16'h8000, so the first sample sets both.
  - alarm=0, busy=0, sample_cnt=0, period counter=0, state=IDLE.
- Period counter:
  - Counts ACLK cycles while enable=1.
  - Reaching SAMPLE_PERIOD-1 raises a trigger and the counter returns to 0.
  - enable=0 clears the counter to 0.
- Trigger = start OR period trigger.
  - Acted on only in IDLE.
  - A trigger while busy is dropped, never queued.
- FSM states: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> UPDATE -> IDLE.
  - Trigger seen in IDLE at cycle t: CS_SETUP begins at t+1. spi_cs_n=0 and busy=1 from t+1.
  - CS_SETUP: CLK_DIV cycles, spi_sclk=0.
  - SHIFT: 16 bit periods of 2*CLK_DIV cycles each, spi_sclk low for CLK_DIV cycles then high for CLK_DIV cycles.
    - spi_miso is sampled into the shift register on the cycle spi_sclk goes 0->1.
    - Bits arrive MSB first.
    - Exactly 16 rising edges per frame.
  - CS_HOLD: CLK_DIV cycles, spi_sclk=0, spi_cs_n=0.
  - UPDATE (cycle t+1+34*CLK_DIV), all in that one cycle:
    - spi_cs_n=1, busy=0.
    - temp_data = sign-extend(frame[15:3]), frame[2:0] ignored.
    - temp_valid=1.
    - sample_cnt+1.
    - Min/max update: compares the new value to the stored values, signed.
    - Alarm update.
  - Trigger-to-temp_valid latency: 34*CLK_DIV+1 cycles.
  - Next trigger accepted from the cycle after UPDATE.
- Alarm, signed compares against the new temp_data:
  - Set when temp_data > thr_high.
  - Cleared when temp_data < thr_low.
  - Otherwise holds.
  - If thr_low > thr_high, the set condition has priority.
- enable deasserted mid-frame: the current frame completes normally.
- ARESETN low mid-frame: all outputs return to reset values on that edge, so spi_cs_n=1 and spi_sclk=0 immediately. The partial frame is discarded.
- temp_data, temp_min, temp_max, alarm and sample_cnt change only in UPDATE or on reset.

Test Plan:
- CLK_DIV=4; start pulse; sensor model returns 16'h0C80 (25.0 °C) -> temp_valid exactly 137 cycles after start; temp_data=16'h0190, temp_min=temp_max=16'h0190, sample_cnt=1, alarm=0.
- Second start; frame 16'hF380 (-25.0 °C) -> temp_data=16'hFE70, temp_min=16'hFE70, temp_max=16'h0190, sample_cnt=2.
- thr_high=16'h0320, thr_low=16'h02D0; frames yielding 16'h0330, then 16'h02E0, then 16'h02C0 -> alarm 1, then 1, then 0.
- enable=1, SAMPLE_PERIOD=2000, CLK_DIV=4 -> temp_valid every 2000 cycles; start pulses while busy=1 produce no extra frame, and sample_cnt advances by exactly 1 per period.
- Protocol check every frame:
  - 16 spi_sclk rising edges, each high and low phase CLK_DIV cycles.
  - spi_cs_n low at least CLK_DIV cycles before the first edge and after the last edge.
  - spi_sclk=0 whenever spi_cs_n=1.
- ARESETN=0 for one cycle during SHIFT bit 7 -> next cycle spi_cs_n=1, spi_sclk=0, temp_min=16'h7FFF, temp_max=16'h8000, sample_cnt=0, busy=0; the following start produces a correct full frame.
